// File: rtl/bcd_interval_ctrl_pkg.sv
// Shared definitions for the BCD interval controller.
//   state_e        : controller FSM encoding (2 bits, three legal states)
//   BCD_W          : width of one decade digit
//   BCD_MAX        : largest legal decade value
//   bcd_digit_inc  : one-digit BCD increment with wrap 9 -> 0
package bcd_interval_ctrl_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Increment a single decade; 9 (or any illegal code) rolls to 0.
  function automatic logic [BCD_W-1:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    if (d >= BCD_MAX) r = '0;
    else              r = BCD_W'(d + BCD_W'(1));
    return r;
  endfunction

endpackage

// File: rtl/bcd_interval_ctrl_bcd_digit.sv
// One decade of the BCD counter chain.
//   clk, clr : clock and asynchronous active-high reset
//   inc      : advance this digit by one (with 9 -> 0 wrap)
//   load0    : synchronous clear to 0, dominates inc
//   q        : current digit value
//   carry    : this digit wraps on the current increment (inc && q == 9)
module bcd_digit
  import bcd_interval_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             load0,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  // Next digit value
  always_comb begin
    q_d = q_q;
    if (load0)    q_d = '0;
    else if (inc) q_d = bcd_digit_inc(q_q);
  end

  // Digit register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_interval_ctrl.sv
// Sequencer for a cascaded BCD counter: latches a BCD target on start,
// counts qualified ticks and pulses done when the count reaches the target.
//   clk, clr : clock and asynchronous active-high reset
//   start    : run request, honoured only in IDLE
//   target   : BCD terminal value (digit 0 in bits [3:0]), sampled with start
//   tick     : count event, one increment per high cycle while running
//   hold     : freezes counting in RUN
//   abort    : returns to IDLE and clears the count from any state
//   count    : current BCD count
//   busy     : high while in RUN
//   done     : one-cycle pulse when the target is reached
//   err      : one-cycle pulse when a start carries a non-BCD target
module bcd_interval_ctrl
  import bcd_interval_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [BCD_W*NDIG-1:0] target,
  input  logic                  tick,
  input  logic                  hold,
  input  logic                  abort,
  output logic [BCD_W*NDIG-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CW = BCD_W * NDIG;

  state_e          state_q, state_d;
  logic [CW-1:0]   target_q, target_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            run_inc;
  logic            load0;
  logic            tgt_valid;
  logic            tgt_zero;
  logic            hit;
  logic [CW-1:0]   count_w;
  logic [CW-1:0]   count_nxt;
  logic [NDIG-1:0] inc_chain;
  logic            carry_top_unused;

  // Counting is qualified here so abort always beats a same-cycle tick.
  assign run_inc = (state_q == ST_RUN) && tick && !hold && !abort;

  // Decade chain: digit i advances when every digit below it wraps.
  assign inc_chain[0] = run_inc;
  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    logic carry_i;

    bcd_digit u_digit (
      .clk   (clk),
      .clr   (clr),
      .inc   (inc_chain[i]),
      .load0 (load0),
      .q     (count_w[i*BCD_W +: BCD_W]),
      .carry (carry_i)
    );

    // Look-ahead of the post-increment value for the target compare.
    assign count_nxt[i*BCD_W +: BCD_W] = inc_chain[i]
        ? bcd_digit_inc(count_w[i*BCD_W +: BCD_W])
        : count_w[i*BCD_W +: BCD_W];

    if (i < NDIG - 1) begin : g_link
      assign inc_chain[i+1] = carry_i;
    end else begin : g_top
      // Target never exceeds 10^NDIG-1, so the top carry cannot fire.
      assign carry_top_unused = carry_i;
    end
  end

  assign hit = run_inc && (count_nxt == target_q);

  // Target qualification: every digit must be a legal BCD code.
  always_comb begin
    tgt_valid = 1'b1;
    tgt_zero  = (target == '0);
    for (int i = 0; i < NDIG; i++) begin
      if (target[i*BCD_W +: BCD_W] > BCD_MAX) tgt_valid = 1'b0;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load0    = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      load0   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!tgt_valid) begin
              err_d = 1'b1;
            end else begin
              load0    = 1'b1;
              target_d = target;
              if (tgt_zero) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_RUN;
                busy_d  = 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d  = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign count = count_w;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_interval_ctrl.sv
module tb_bcd_interval_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic [7:0] target;
  logic       tick;
  logic       hold;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       err;

  int tests;
  int fails;

  bcd_interval_ctrl #(.NDIG(2)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .target (target),
    .tick   (tick),
    .hold   (hold),
    .abort  (abort),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  // Advance one clock; outputs are then stable for checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tick n times while running, checking count and that done stays low.
  task automatic run_ticks(input int from, input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      tick = 1'b1;
      step();
      tests++;
      if (count !== to_bcd(from + k) || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s k=%0d count=%h busy=%b done=%b need count=%h busy=1 done=0",
                 tag, k, count, busy, done, to_bcd(from + k));
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; target = '0; tick = 1'b0; hold = 1'b0; abort = 1'b0;
    #3;
    tests++;
    if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset count=%h busy=%b done=%b err=%b need all 0", count, busy, done, err);
    end
    @(negedge clk);
    clr = 1'b0;
    step();
  endtask

  task automatic test_count_12();
    start = 1'b1; target = 8'h12;
    step();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || count !== 8'h00 || done !== 1'b0) begin
      fails++;
      $display("FAIL c12_start busy=%b count=%h done=%b need busy=1 count=00 done=0", busy, count, done);
    end
    run_ticks(0, 11, "c12_tick");
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (count !== 8'h12 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL c12_done count=%h done=%b busy=%b need 12 1 0", count, done, busy);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 8'h12) begin
      fails++;
      $display("FAIL c12_after done=%b busy=%b count=%h need 0 0 12", done, busy, count);
    end
  endtask

  task automatic test_invalid_target();
    start = 1'b1; target = 8'h1A;
    step();
    start = 1'b0;
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || count !== 8'h12) begin
      fails++;
      $display("FAIL bad_tgt err=%b busy=%b done=%b count=%h need 1 0 0 12", err, busy, done, count);
    end
    step();
    tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bad_tgt_after err=%b busy=%b need 0 0", err, busy);
    end
  endtask

  task automatic test_zero_target();
    start = 1'b1; target = 8'h00;
    step();
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || count !== 8'h00) begin
      fails++;
      $display("FAIL zero_tgt done=%b busy=%b err=%b count=%h need 1 0 0 00", done, busy, err, count);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_tgt_after done=%b busy=%b need 0 0", done, busy);
    end
  endtask

  task automatic test_hold();
    start = 1'b1; target = 8'h25;
    step();
    start = 1'b0;
    run_ticks(0, 7, "hold_pre");
    hold = 1'b1; tick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (count !== 8'h07 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold_freeze k=%0d count=%h busy=%b need 07 1", k, count, busy);
      end
    end
    hold = 1'b0;
    step();
    tick = 1'b0;
    tests++;
    if (count !== 8'h08) begin
      fails++;
      $display("FAIL hold_release count=%h need 08", count);
    end
    // Start and a new target mid-run must be ignored.
    start = 1'b1; target = 8'h03;
    step();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || count !== 8'h08 || err !== 1'b0) begin
      fails++;
      $display("FAIL hold_restart busy=%b count=%h err=%b need 1 08 0", busy, count, err);
    end
    run_ticks(8, 16, "hold_post");
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (count !== 8'h25 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_done count=%h done=%b busy=%b need 25 1 0", count, done, busy);
    end
    step();
  endtask

  task automatic test_abort();
    start = 1'b1; target = 8'h99;
    step();
    start = 1'b0;
    run_ticks(0, 42, "abort_pre");
    abort = 1'b1; tick = 1'b1;
    step();
    abort = 1'b0; tick = 1'b0;
    tests++;
    if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort count=%h busy=%b done=%b need 00 0 0", count, busy, done);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle count=%h busy=%b done=%b need 00 0 0", count, busy, done);
    end
  endtask

  task automatic test_async_clr();
    start = 1'b1; target = 8'h25;
    step();
    start = 1'b0;
    run_ticks(0, 9, "clr_pre");
    #3;
    clr = 1'b1;
    #1;
    tests++;
    if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_clr count=%h busy=%b done=%b err=%b need all 0", count, busy, done, err);
    end
    clr = 1'b0;
    start = 1'b1; target = 8'h03;
    step();
    start = 1'b0;
    run_ticks(0, 2, "clr_post");
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (count !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clr_post_done count=%h done=%b busy=%b need 03 1 0", count, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    // Still in DONE from the previous scenario: this start must be ignored.
    start = 1'b1; target = 8'h01;
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || count !== 8'h03) begin
      fails++;
      $display("FAIL b2b_ignore busy=%b done=%b err=%b count=%h need 0 0 0 03", busy, done, err, count);
    end
    step();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || count !== 8'h00) begin
      fails++;
      $display("FAIL b2b_accept busy=%b count=%h need 1 00", busy, count);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (done !== 1'b1 || count !== 8'h01 || err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done done=%b count=%h err=%b need 1 01 0", done, count, err);
    end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_count_12();
    test_invalid_target();
    test_zero_target();
    test_hold();
    test_abort();
    test_async_clr();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
